// File: rtl/countdown_hms.sv
// Hours/minutes/seconds countdown timer with load, start and pause controls.
// All outputs are registered; load values are range-checked before acceptance.
module countdown_hms #(
  parameter int unsigned HOURS_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [4:0] ld_hr,
  input  logic [5:0] ld_min,
  input  logic [5:0] ld_sec,
  input  logic       start,
  input  logic       pause,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  localparam logic [4:0] HrMax  = 5'(HOURS_MAX);
  localparam logic [5:0] MinSec = 6'd59;

  state_e     state_q;
  logic [4:0] hr_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic       done_q;
  logic       load_err_q;

  logic load_ok;
  logic count_zero;
  logic count_one;

  // Load values are only usable if every field is within its range.
  assign load_ok    = (ld_hr <= HrMax) && (ld_min <= MinSec) && (ld_sec <= MinSec);
  assign count_zero = (hr_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);
  assign count_one  = (hr_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd1);

  // Control FSM and count registers; done/load_err default low so they pulse one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hr_q       <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          // Load is ignored here; pause beats both start and tick.
          if (pause) begin
            state_q <= StPaused;
          end else if (tick) begin
            if (count_one) begin
              sec_q   <= 6'd0;
              state_q <= StExpired;
              done_q  <= 1'b1;
            end else if (sec_q != 6'd0) begin
              sec_q <= sec_q - 6'd1;
            end else begin
              sec_q <= MinSec;
              if (min_q != 6'd0) begin
                min_q <= min_q - 6'd1;
              end else begin
                min_q <= MinSec;
                hr_q  <= hr_q - 5'd1;
              end
            end
          end
        end
        StIdle, StPaused, StExpired: begin
          // Load wins over start; a rejected load leaves state and count alone.
          if (load) begin
            if (load_ok) begin
              hr_q    <= ld_hr;
              min_q   <= ld_min;
              sec_q   <= ld_sec;
              state_q <= StIdle;
            end else begin
              load_err_q <= 1'b1;
            end
          end else if (start && !pause && !count_zero && (state_q != StExpired)) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hr       = hr_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign running  = (state_q == StRun);
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_hms.sv
// Directed scoreboard bench for countdown_hms: each step pushes the expected
// post-edge outputs, then pops and compares them one edge later.
module tb_countdown_hms;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       load;
  logic [4:0] ld_hr;
  logic [5:0] ld_min;
  logic [5:0] ld_sec;
  logic       start;
  logic       pause;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;
  logic       done;
  logic       load_err;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       r;
    logic       d;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  countdown_hms #(.HOURS_MAX(23)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (load),
    .ld_hr    (ld_hr),
    .ld_min   (ld_min),
    .ld_sec   (ld_sec),
    .start    (start),
    .pause    (pause),
    .hr       (hr),
    .min      (min),
    .sec      (sec),
    .running  (running),
    .done     (done),
    .load_err (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag,
                      input logic tk, input logic ld, input logic st, input logic ps,
                      input logic [4:0] lh, input logic [5:0] lm, input logic [5:0] ls,
                      input logic [4:0] eh, input logic [5:0] em, input logic [5:0] es,
                      input logic er, input logic ed, input logic ee);
    exp_t e;
    tick   = tk;
    load   = ld;
    start  = st;
    pause  = ps;
    ld_hr  = lh;
    ld_min = lm;
    ld_sec = ls;
    exp_q.push_back('{h: eh, m: em, s: es, r: er, d: ed, e: ee});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".count"}, {15'd0, hr, min, sec}, {15'd0, e.h, e.m, e.s});
    check({tag, ".flags"}, {29'd0, running, done, load_err}, {29'd0, e.r, e.d, e.e});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    tick     = 1'b0;
    load     = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    ld_hr    = '0;
    ld_min   = '0;
    ld_sec   = '0;
    #12;
    check("reset.count", {15'd0, hr, min, sec}, 32'd0);
    check("reset.flags", {29'd0, running, done, load_err}, 32'd0);
    rst_n = 1'b1;

    //    tag          tk ld st ps  lh  lm  ls   eh  em  es  r  d  e
    step("start_zero",  0, 0, 1, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0);
    step("ld_0100",     0, 1, 0, 0,  0,  1,  0,   0,  1,  0, 0, 0, 0);
    step("tick_idle",   1, 0, 0, 0,  0,  0,  0,   0,  1,  0, 0, 0, 0);
    step("start1",      0, 0, 1, 0,  0,  0,  0,   0,  1,  0, 1, 0, 0);
    step("tick_0059",   1, 0, 0, 0,  0,  0,  0,   0,  0, 59, 1, 0, 0);
    step("pause1",      0, 0, 0, 1,  0,  0,  0,   0,  0, 59, 0, 0, 0);
    step("tick_paused", 1, 0, 0, 0,  0,  0,  0,   0,  0, 59, 0, 0, 0);
    step("ld_1h",       0, 1, 0, 0,  1,  0,  0,   1,  0,  0, 0, 0, 0);
    step("start2",      0, 0, 1, 0,  0,  0,  0,   1,  0,  0, 1, 0, 0);
    step("dbl_borrow",  1, 0, 0, 0,  0,  0,  0,   0, 59, 59, 1, 0, 0);
    step("ld_in_run",   0, 1, 0, 0,  0,  0,  2,   0, 59, 59, 1, 0, 0);
    step("bad_ld_run",  0, 1, 0, 0, 24,  0,  0,   0, 59, 59, 1, 0, 0);
    step("pause2",      0, 0, 0, 1,  0,  0,  0,   0, 59, 59, 0, 0, 0);
    step("bad_hr24",    0, 1, 0, 0, 24,  0,  0,   0, 59, 59, 0, 0, 1);
    step("err_clear",   0, 0, 0, 0,  0,  0,  0,   0, 59, 59, 0, 0, 0);
    step("bad_min60",   0, 1, 0, 0,  0, 60,  0,   0, 59, 59, 0, 0, 1);
    step("bad_sec60",   0, 1, 1, 0,  0,  0, 60,   0, 59, 59, 0, 0, 1);
    step("resume",      0, 0, 1, 0,  0,  0,  0,   0, 59, 59, 1, 0, 0);
    step("tick_5958",   1, 0, 0, 0,  0,  0,  0,   0, 59, 58, 1, 0, 0);
    step("pause3",      0, 0, 0, 1,  0,  0,  0,   0, 59, 58, 0, 0, 0);
    step("ld_start",    0, 1, 1, 0,  0,  0,  2,   0,  0,  2, 0, 0, 0);
    step("start3",      0, 0, 1, 0,  0,  0,  0,   0,  0,  2, 1, 0, 0);
    step("tick_0001",   1, 0, 0, 0,  0,  0,  0,   0,  0,  1, 1, 0, 0);
    step("expire",      1, 0, 0, 0,  0,  0,  0,   0,  0,  0, 0, 1, 0);
    step("done_clear",  0, 0, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0);
    step("tick_exp",    1, 0, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0);
    step("start_exp",   0, 0, 1, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0);
    step("bad_ld_exp",  0, 1, 0, 0, 31,  0,  0,   0,  0,  0, 0, 0, 1);
    step("ld_0010",     0, 1, 0, 0,  0,  0, 10,   0,  0, 10, 0, 0, 0);
    step("start4",      0, 0, 1, 0,  0,  0,  0,   0,  0, 10, 1, 0, 0);
    step("pause_tick",  1, 0, 0, 1,  0,  0,  0,   0,  0, 10, 0, 0, 0);
    step("start5",      0, 0, 1, 0,  0,  0,  0,   0,  0, 10, 1, 0, 0);
    step("tick_0009",   1, 0, 0, 0,  0,  0,  0,   0,  0,  9, 1, 0, 0);
    step("pause_start", 0, 0, 1, 1,  0,  0,  0,   0,  0,  9, 0, 0, 0);
    step("ps_in_pause", 0, 0, 1, 1,  0,  0,  0,   0,  0,  9, 0, 0, 0);
    step("ld_max",      0, 1, 0, 0, 23, 59, 59,  23, 59, 59, 0, 0, 0);
    step("start6",      0, 0, 1, 0,  0,  0,  0,  23, 59, 59, 1, 0, 0);
    step("tick_max",    1, 0, 0, 0,  0,  0,  0,  23, 59, 58, 1, 0, 0);
    step("pause4",      0, 0, 0, 1,  0,  0,  0,  23, 59, 58, 0, 0, 0);
    step("ld_0530",     0, 1, 0, 0,  0,  5, 30,   0,  5, 30, 0, 0, 0);
    step("start7",      0, 0, 1, 0,  0,  0,  0,   0,  5, 30, 1, 0, 0);

    // Asynchronous reset between edges must clear outputs immediately.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.count", {15'd0, hr, min, sec}, 32'd0);
    check("async_rst.flags", {29'd0, running, done, load_err}, 32'd0);
    #1;
    rst_n = 1'b1;

    step("post_rst",    1, 0, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0);
    step("post_start",  0, 0, 1, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0);
    step("post_ld",     0, 1, 0, 0,  0,  0,  1,   0,  0,  1, 0, 0, 0);

    if (exp_q.size() != 0) begin
      check("queue_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_hms.md
COUNTDOWN_HMS -- requirements
Module: countdown_hms

Interface
REQ-001 SHALL have parameter HOURS_MAX, default 23, giving the highest hour value accepted on load.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 SHALL have port tick, input, 1, a one-cycle 1 Hz strobe that decrements the count.
REQ-005 SHALL have port load, input, 1, a one-cycle request to preset the count.
REQ-006 SHALL have port ld_hr, input, 5, the hours load value.
REQ-007 SHALL have port ld_min, input, 6, the minutes load value.
REQ-008 SHALL have port ld_sec, input, 6, the seconds load value.
REQ-009 SHALL have port start, input, 1, a one-cycle request to begin or resume counting.
REQ-010 SHALL have port pause, input, 1, a one-cycle request to halt counting.
REQ-011 SHALL have ports hr (output, 5), min (output, 6) and sec (output, 6), the registered current count.
REQ-012 SHALL have port running, output, 1, which is high while in the RUN state.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse when the count reaches 00:00:00.
REQ-014 SHALL have port load_err, output, 1, a one-cycle pulse when a load is rejected.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN, PAUSED and EXPIRED; running SHALL equal (state==RUN).
REQ-016 SHALL sample all inputs at edge n and make the resulting outputs visible after edge n (one-cycle latency).
REQ-017 SHALL accept load only in IDLE, PAUSED or EXPIRED; an accepted load sets hr/min/sec to the load values and the state to IDLE.
REQ-018 SHALL ignore load in RUN: count, state and load_err are all unchanged.
REQ-019 SHALL reject a load with ld_hr>HOURS_MAX, ld_min>59 or ld_sec>59: load_err pulses for one cycle, and count and state are unchanged.
REQ-020 SHALL move from IDLE or PAUSED to RUN on start when the count is nonzero; start with count 00:00:00 SHALL be ignored.
REQ-021 SHALL, in RUN with tick high: if sec>0 decrement sec; else set sec=59 and, if min>0, decrement min; else set min=59 and decrement hr.
REQ-022 SHALL ignore tick in IDLE, PAUSED and EXPIRED.
REQ-023 SHALL, when a RUN tick takes the count from 00:00:01 to 00:00:00, enter EXPIRED and assert done for exactly one cycle, aligned with the count first reading zero.
REQ-024 SHALL move from RUN to PAUSED on pause with no decrement, even if tick is high in the same cycle (pause beats tick).
REQ-025 SHALL give pause priority over start when both are high in the same cycle; from RUN this yields PAUSED.
REQ-026 SHALL, when load and start are high in the same cycle in IDLE or PAUSED, apply the load and ignore the start (state IDLE).
REQ-027 SHALL ignore start in EXPIRED; only a valid load leaves EXPIRED.
REQ-028 SHALL never present min>59, sec>59 or hr>HOURS_MAX on its outputs.

Reset
REQ-029 SHALL, while rst_n is low, immediately force state=IDLE, hr=0, min=0, sec=0, running=0, done=0 and load_err=0, regardless of clk.
REQ-030 SHALL abort any count in progress on reset, with no done pulse.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-032 SHALL pass: load 00:01:00, start, 1 tick -> 00:00:59, running=1.
REQ-033 SHALL pass: load 01:00:00, start, 1 tick -> 00:59:59 (double borrow).
REQ-034 SHALL pass: load 00:00:02, start, 2 ticks -> 00:00:00, done high for exactly one cycle, state EXPIRED; a further tick or start -> no change.
REQ-035 SHALL pass: in RUN at 00:00:10, pause and tick in the same cycle -> 00:00:10, state PAUSED; then start and 1 tick -> 00:00:09.
REQ-036 SHALL pass: load 24:00:00 or 00:60:00 with the default parameter -> load_err pulses once and the count is unchanged; a load during RUN is ignored.
REQ-037 SHALL pass: assert rst_n low mid-count at 00:05:30 between clock edges -> outputs read 00:00:00 at once, with running=0 and done=0.
